// File: rtl/cordic_pkg.sv
// ============================================================================
// Module      : cordic_pkg
// Description : Shared types and constants for the iterative vectoring CORDIC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_COMP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Reciprocal CORDIC gain in Q16.
  localparam int unsigned K_Q16 = 39797;

  // round(atan(2^-i) * 2^16 / (pi/2))
  function automatic logic [31:0] atan_q16(input logic [31:0] idx);
    case (idx)
      32'd0:   return 32'd32768;
      32'd1:   return 32'd19344;
      32'd2:   return 32'd10221;
      32'd3:   return 32'd5188;
      32'd4:   return 32'd2604;
      32'd5:   return 32'd1303;
      32'd6:   return 32'd652;
      32'd7:   return 32'd326;
      32'd8:   return 32'd163;
      32'd9:   return 32'd81;
      32'd10:  return 32'd41;
      32'd11:  return 32'd20;
      32'd12:  return 32'd10;
      32'd13:  return 32'd5;
      32'd14:  return 32'd3;
      32'd15:  return 32'd1;
      32'd16:  return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // Rescale the Q16 table to an arbitrary angle width, rounding to nearest.
  function automatic logic [31:0] atan_scaled(input logic [31:0] idx, input int asize);
    logic [31:0] v;
    v = atan_q16(idx);
    if (asize >= 16) return v << (asize - 16);
    return (v + (32'd1 << (15 - asize))) >> (16 - asize);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_micro_rot.sv
// ============================================================================
// Module      : cordic_micro_rot
// Description : One combinational vectoring micro-rotation (shift-add/sub pair).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_micro_rot #(
  parameter int XW = 19,
  parameter int ZW = 18,
  parameter int CW = 4
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic        [CW-1:0] shift_i,
  input  logic signed [ZW-1:0] atan_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;

  assign w_xs = x_i >>> shift_i;
  assign w_ys = y_i >>> shift_i;

  // Rotate toward the x axis; both updates see the pre-step x and y.
  always_comb begin
    x_o = x_i;
    y_o = y_i;
    z_o = z_i;
    if (!y_i[XW-1]) begin
      x_o = x_i + w_ys;
      y_o = y_i - w_xs;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - w_ys;
      y_o = y_i + w_xs;
      z_o = z_i - atan_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_vector_iter.sv
// ============================================================================
// Module      : cordic_vector_iter
// Description : Iterative vectoring CORDIC, (x,y) -> (magnitude, angle).
//               Optional gain compensation under CORDIC_GAIN_COMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_vector_iter
  import cordic_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int ASIZE = 16,
  parameter int ITER  = 14
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] x_in,
  input  logic [DSIZE-1:0] y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] mag_out,
  output logic [ASIZE-1:0] ang_out,
  output logic             busy
);

  // Three guard bits on x/y: the raw gain on a full-scale diagonal exceeds 2^(DSIZE+1).
  localparam int XW = DSIZE + 3;
  localparam int ZW = ASIZE + 2;
  localparam int GW = XW + 1;
  localparam int CW = (ITER < 2) ? 1 : $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER);

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic signed [XW-1:0] x_q, y_q;
  logic signed [ZW-1:0] z_q;
  logic                 zero_q;
  logic [DSIZE-1:0]     mag_q;
  logic [ASIZE-1:0]     ang_q;
  logic                 out_valid_q, in_ready_q, busy_q;

  logic signed [XW-1:0] x_d, y_d;
  logic signed [ZW-1:0] z_d;
  logic signed [ZW-1:0] w_atan;
  logic signed [GW-1:0] w_mag_src;
  logic [DSIZE-1:0]     w_mag_sat;
  logic [ASIZE-1:0]     w_ang_sat;

  assign w_atan = ZW'(atan_scaled(32'(cnt_q), ASIZE));

  cordic_micro_rot #(
    .XW (XW),
    .ZW (ZW),
    .CW (CW)
  ) u_micro_rot (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (cnt_q),
    .atan_i  (w_atan),
    .x_o     (x_d),
    .y_o     (y_d),
    .z_o     (z_d)
  );

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [XW+16:0] w_prod;
  logic signed [GW-1:0]  w_gain;
  assign w_prod = x_q * $signed({1'b0, 16'(K_Q16)});
  assign w_gain = GW'(w_prod >>> 16);
`endif

  always_comb begin
    w_mag_src = {x_q[XW-1], x_q};
`ifdef CORDIC_GAIN_COMP_EN
    if (state_q == S_COMP && !zero_q) w_mag_src = w_gain;
`endif
    if (w_mag_src[GW-1])               w_mag_sat = '0;
    else if (|w_mag_src[GW-2:DSIZE])   w_mag_sat = '1;
    else                               w_mag_sat = w_mag_src[DSIZE-1:0];

    if (z_q[ZW-1])                     w_ang_sat = '0;
    else if (|z_q[ZW-2:ASIZE])         w_ang_sat = '1;
    else                               w_ang_sat = z_q[ASIZE-1:0];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      zero_q      <= 1'b0;
      mag_q       <= '0;
      ang_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q        <= $signed({{(XW-DSIZE){1'b0}}, x_in});
            y_q        <= $signed({{(XW-DSIZE){1'b0}}, y_in});
            z_q        <= '0;
            zero_q     <= (y_in == '0);
            cnt_q      <= '0;
            state_q    <= S_ITER;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_ITER: begin
          // The pass at cnt==ITER performs no rotation; it only finalises the result.
          if (cnt_q == LAST_CNT) begin
`ifdef CORDIC_GAIN_COMP_EN
            state_q     <= S_COMP;
`else
            state_q     <= S_DONE;
            mag_q       <= w_mag_sat;
            ang_q       <= w_ang_sat;
            out_valid_q <= 1'b1;
`endif
          end else begin
            if (!zero_q) begin
              x_q <= x_d;
              y_q <= y_d;
              z_q <= z_d;
            end
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_COMP: begin
          state_q     <= S_DONE;
          mag_q       <= w_mag_sat;
          ang_q       <= w_ang_sat;
          out_valid_q <= 1'b1;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mag_out   = mag_q;
  assign ang_out   = ang_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_vector_iter.sv
// ============================================================================
// Module      : tb_cordic_vector_iter
// Description : Self-checking bench for cordic_vector_iter against a real-valued
//               magnitude/angle model. Honours CORDIC_GAIN_COMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_vector_iter;

  localparam int DSIZE = 16;
  localparam int ASIZE = 16;
  localparam int ITER  = 14;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 2;
`else
  localparam int LAT = ITER + 1;
`endif
  localparam real PI = 3.14159265358979323846;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] x_in;
  logic [DSIZE-1:0] y_in;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] mag_out;
  logic [ASIZE-1:0] ang_out;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cordic_vector_iter #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .ITER  (ITER)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag_out   (mag_out),
    .ang_out   (ang_out),
    .busy      (busy)
  );

  // Ideal result: true magnitude (times the CORDIC gain when uncompensated) and atan2 angle.
  function automatic void model(input int x, input int y, output int mag, output int ang);
    real r, g, a;
    if (y == 0) begin
      mag = x;
      ang = 0;
      return;
    end
    r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    g = 1.0;
`ifndef CORDIC_GAIN_COMP_EN
    for (int i = 0; i < ITER; i++) g = g * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`endif
    r = r * g;
    a = $atan2(real'(y), real'(x)) * 65536.0 / (PI / 2.0);
    mag = (r > 65535.0) ? 65535 : int'(r);
    ang = (a > 65535.0) ? 65535 : ((a < 0.0) ? 0 : int'(a));
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic send(input int x, input int y);
    bit ok;
    @(negedge clock);
    in_valid = 1'b1;
    x_in     = DSIZE'(x);
    y_in     = DSIZE'(y);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=in_ready_low exp=in_ready_high");
    end
  endtask

  // Returns once out_valid is seen, #1 after the edge that raised it.
  task automatic wait_out(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clock);
      cyc++;
      #1;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL result_timeout got=no_out_valid exp=out_valid");
    end
  endtask

  task automatic run_vec(input int x, input int y, output int mag, output int ang, output int cyc);
    bit ok;
    send(x, y);
    wait_out(ok, cyc);
    mag = int'(mag_out);
    ang = int'(ang_out);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({out_valid, busy, in_ready, mag_out, ang_out} !== {1'b0, 1'b0, 1'b1, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_hold got=v%0b b%0b r%0b m%0d a%0d exp=v0 b0 r1 m0 a0",
               out_valid, busy, in_ready, mag_out, ang_out);
    end
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if ({out_valid, busy, in_ready, mag_out, ang_out} !== {1'b0, 1'b0, 1'b1, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_release got=v%0b b%0b r%0b m%0d a%0d exp=v0 b0 r1 m0 a0",
               out_valid, busy, in_ready, mag_out, ang_out);
    end
  endtask

  task automatic test_zero_y();
    int mag, ang, cyc;
    int xs[3] = '{1000, 0, 65535};
    foreach (xs[k]) begin
      run_vec(xs[k], 0, mag, ang, cyc);
      checks++;
      if (mag !== xs[k] || ang !== 0) begin
        errors++;
        $display("FAIL zero_y x=%0d got=m%0d a%0d exp=m%0d a0", xs[k], mag, ang, xs[k]);
      end
      checks++;
      if (cyc !== LAT) begin
        errors++;
        $display("FAIL latency x=%0d got=%0d exp=%0d", xs[k], cyc, LAT);
      end
    end
  endtask

  task automatic test_spec_vectors();
    int mag, ang, cyc;
`ifdef CORDIC_GAIN_COMP_EN
    run_vec(20000, 20000, mag, ang, cyc);
    checks++;
    if (absdiff(mag, 28284) > 3 || absdiff(ang, 32768) > 3) begin
      errors++;
      $display("FAIL diag_comp got=m%0d a%0d exp=m28284 a32768 (+-3)", mag, ang);
    end
    run_vec(0, 30000, mag, ang, cyc);
    checks++;
    if (absdiff(mag, 30000) > 3 || ang < 65530) begin
      errors++;
      $display("FAIL yaxis_comp got=m%0d a%0d exp=m30000(+-3) a>=65530", mag, ang);
    end
`else
    run_vec(65535, 65535, mag, ang, cyc);
    checks++;
    if (mag !== 65535 || absdiff(ang, 32768) > 3) begin
      errors++;
      $display("FAIL diag_sat got=m%0d a%0d exp=m65535 a32768 (+-3)", mag, ang);
    end
    run_vec(0, 30000, mag, ang, cyc);
    checks++;
    if (mag !== 49403 && absdiff(mag, 49403) > 24 || ang < 65500) begin
      errors++;
      $display("FAIL yaxis_raw got=m%0d a%0d exp=m49403(+-24) a>=65500", mag, ang);
    end
`endif
  endtask

  task automatic test_random();
    int x, y, mag, ang, cyc, em, ea;
    for (int n = 0; n < 24; n++) begin
      x = int'($urandom_range(65535, 0));
      y = int'($urandom_range(65535, 1));
      if (x < 12000 && y < 12000) x = x + 12000;
      model(x, y, em, ea);
      run_vec(x, y, mag, ang, cyc);
      checks++;
      if (absdiff(mag, em) > 24) begin
        errors++;
        $display("FAIL rand_mag x=%0d y=%0d got=%0d exp=%0d", x, y, mag, em);
      end
      checks++;
      if (absdiff(ang, ea) > 48) begin
        errors++;
        $display("FAIL rand_ang x=%0d y=%0d got=%0d exp=%0d", x, y, ang, ea);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc, m0, a0, em, ea, mag, ang;
    bit stable;
    out_ready = 1'b0;
    send(30000, 10000);
    wait_out(ok, cyc);
    m0 = int'(mag_out);
    a0 = int'(ang_out);
    stable = 1'b1;
    @(negedge clock);
    in_valid = 1'b1;
    x_in     = 16'd500;
    y_in     = 16'd40000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (!out_valid || in_ready || int'(mag_out) != m0 || int'(ang_out) != a0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_done got=unstable exp=valid_stable_inready_low");
    end
    x_in      = 16'd50000;
    y_in      = 16'd20000;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake got=r%0b v%0b exp=r1 v0", in_ready, out_valid);
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL next_accept got=b%0b r%0b exp=b1 r0", busy, in_ready);
    end
    wait_out(ok, cyc);
    mag = int'(mag_out);
    ang = int'(ang_out);
    @(posedge clock);
    #1;
    model(50000, 20000, em, ea);
    checks++;
    if (absdiff(mag, em) > 24 || absdiff(ang, ea) > 48) begin
      errors++;
      $display("FAIL next_result got=m%0d a%0d exp=m%0d a%0d", mag, ang, em, ea);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    send(40000, 25000);
    repeat (5) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, mag_out, ang_out} !== {1'b0, 1'b0, 1'b1, 16'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_mid got=v%0b b%0b r%0b m%0d a%0d exp=v0 b0 r1 m0 a0",
               out_valid, busy, in_ready, mag_out, ang_out);
    end
    @(negedge clock);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_discard got=out_valid_seen exp=no_out_valid");
    end
  endtask

  initial begin
    test_reset();
    test_zero_y();
    test_spec_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
